// File: rtl/regfile_sb.sv
// Multi-port register file with per-register scoreboard busy bits
// and a sequential whole-file clear sequencer.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                init_req,
   output logic                ready
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   regs [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [NREG-1:0]   we;
   logic [XLEN-1:0]   wd [NREG];

   assign ready = (state_q == IDLE);

   // FSM and clear counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep the counter through every register once
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == AW'(NREG - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Per-register write decode; later ports override earlier ones
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         we[r] = 1'b0;
         wd[r] = '0;
         if (state_q == CLEAR) begin
            if (cnt_q == AW'(r))
               we[r] = 1'b1;
         end else if (r != 0) begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) begin
                  we[r] = 1'b1;
                  wd[r] = wr_data[p*XLEN +: XLEN];
               end
            end
         end
      end
   end

   // Busy next: writes clear, a same-cycle issue sets on top of that
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREG; r++) begin
         if (we[r])
            busy_d[r] = 1'b0;
         if (state_q == IDLE && iss_en && r != 0
             && iss_addr == AW'(r))
            busy_d[r] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Register array and busy storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++)
            regs[r] <= '0;
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++)
            if (we[r])
               regs[r] <= wd[r];
         busy_q <= busy_d;
      end
   end

   // Read ports with write bypass; everything reads 0 while clearing
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0]   a;
         logic [XLEN-1:0] d;
         logic            b;
         logic            byp;
         a   = rd_addr[i*AW +: AW];
         d   = '0;
         b   = 1'b0;
         byp = 1'b0;
         if (state_q == IDLE && a != '0 && int'(a) < NREG) begin
            d = regs[a];
            b = busy_q[a];
            for (int p = 0; p < NWR; p++) begin
               if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
                  d   = wr_data[p*XLEN +: XLEN];
                  byp = 1'b1;
               end
            end
         end
         rd_data[i*XLEN +: XLEN] = d;
         rd_busy[i]              = b & ~byp;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table,
// hand sequences for clear/reset, and random traffic vs a model.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [2*AW-1:0]  rd_addr;
   logic [2*XLEN-1:0] rd_data;
   logic [1:0]       rd_busy;
   logic [1:0]       wr_en;
   logic [2*AW-1:0]  wr_addr;
   logic [2*XLEN-1:0] wr_data;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic             init_req;
   logic             ready;

   int n_vec = 0;
   int n_bad = 0;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2)) dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .init_req(init_req), .ready(ready)
   );

   always #5 clk = ~clk;

   // reference model: architectural state as plain arrays
   logic [31:0] m_reg [NREG];
   bit          m_busy [NREG];
   bit          m_clr;
   int          m_cnt;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic int wa(int p);
      return int'(wr_addr[p*AW +: AW]);
   endfunction

   function automatic logic [31:0] wdat(int p);
      return wr_data[p*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] exp_data(int a);
      logic [31:0] d;
      if (m_clr || a == 0) return 32'h0;
      d = m_reg[a];
      for (int p = 0; p < 2; p++)
         if (wr_en[p] && wa(p) == a) d = wdat(p);
      return d;
   endfunction

   function automatic logic exp_busy(int a);
      if (m_clr || a == 0) return 1'b0;
      for (int p = 0; p < 2; p++)
         if (wr_en[p] && wa(p) == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
      m_clr = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_edge();
      if (m_clr) begin
         m_reg[m_cnt]  = '0;
         m_busy[m_cnt] = 1'b0;
         m_cnt++;
         if (m_cnt == NREG) m_clr = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (wr_en[p] && wa(p) != 0) begin
               m_reg[wa(p)]  = wdat(p);
               m_busy[wa(p)] = 1'b0;
            end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
         if (init_req) begin
            m_clr = 1'b1;
            m_cnt = 0;
         end
      end
   endtask

   task automatic idle_in();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 0; iss_addr = '0; init_req = 0;
   endtask

   // compare against the model at negedge, then advance one edge
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rd_data", rd_data[i*XLEN +: XLEN],
             exp_data(int'(rd_addr[i*AW +: AW])));
         chk("rd_busy", 32'(rd_busy[i]),
             32'(exp_busy(int'(rd_addr[i*AW +: AW]))));
      end
      chk("ready", 32'(ready), 32'(!m_clr));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        ie;
      logic [4:0]  ia;
      logic [4:0]  ra0, ra1;
      logic [31:0] e0, e1;
      logic [1:0]  eb;
   } vec_t;

   vec_t tab [13];

   initial begin
      // we  wa0 wa1 wd0          wd1    ie ia ra0 ra1 e0           e1           eb
      tab[0]  = '{2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 5, 0,
                  32'hDEADBEEF, 0, 2'b00};
      tab[1]  = '{2'b01, 0, 0, 32'h1234, 0, 0, 0, 0, 5,
                  0, 32'hDEADBEEF, 2'b00};
      tab[2]  = '{2'b11, 7, 7, 32'h11, 32'h22, 0, 0, 7, 7,
                  32'h22, 32'h22, 2'b00};
      tab[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 7, 5,
                  32'h22, 32'hDEADBEEF, 2'b00};
      tab[4]  = '{2'b00, 0, 0, 0, 0, 1, 3, 3, 3,
                  0, 0, 2'b00};
      tab[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 7,
                  0, 32'h22, 2'b01};
      tab[6]  = '{2'b01, 3, 0, 32'h55, 0, 0, 0, 3, 3,
                  32'h55, 32'h55, 2'b00};
      tab[7]  = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 0,
                  32'h55, 0, 2'b00};
      tab[8]  = '{2'b10, 0, 9, 0, 32'h99, 1, 9, 9, 0,
                  32'h99, 0, 2'b00};
      tab[9]  = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 9,
                  32'h99, 32'h99, 2'b11};
      tab[10] = '{2'b01, 9, 0, 32'hAA, 0, 0, 0, 9, 3,
                  32'hAA, 32'h55, 2'b00};
      tab[11] = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 0,
                  0, 0, 2'b00};
      tab[12] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 9,
                  0, 32'hAA, 2'b00};

      idle_in();
      rd_addr = '0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_rd", rd_data[31:0], 32'h0);
      chk("reset_busy", 32'(rd_busy), 32'h0);
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // directed table
      for (int k = 0; k < 13; k++) begin
         wr_en = tab[k].we;
         wr_addr = {tab[k].wa1, tab[k].wa0};
         wr_data = {tab[k].wd1, tab[k].wd0};
         iss_en = tab[k].ie;
         iss_addr = tab[k].ia;
         rd_addr = {tab[k].ra1, tab[k].ra0};
         init_req = 0;
         @(negedge clk);
         chk($sformatf("tab%0d_rd0", k), rd_data[31:0], tab[k].e0);
         chk($sformatf("tab%0d_rd1", k), rd_data[63:32], tab[k].e1);
         chk($sformatf("tab%0d_busy", k), 32'(rd_busy), 32'(tab[k].eb));
         chk($sformatf("tab%0d_ready", k), 32'(ready), 32'd1);
         @(posedge clk);
         model_edge();
         #1;
      end

      // fill every register, then clear with a write attempted mid-clear
      for (int r = 1; r < NREG; r++) begin
         idle_in();
         wr_en = 2'b01;
         wr_addr = {5'd0, 5'(r)};
         wr_data = {32'h0, 32'h1000 + 32'(r)};
         iss_en = 1; iss_addr = 5'(r);
         rd_addr = {5'(r), 5'(r - 1)};
         step();
      end
      idle_in();
      init_req = 1;
      step();
      begin
         int lo = 0;
         for (int c = 0; c < 100 && !ready; c++) begin
            idle_in();
            if (c == 4) begin
               wr_en = 2'b11; wr_addr = {5'd6, 5'd5};
               wr_data = {32'hBAD6, 32'hBAD5};
               iss_en = 1; iss_addr = 5'd5; init_req = 1;
            end
            rd_addr = {5'd6, 5'd5};
            @(negedge clk);
            if (!ready) lo++;
            chk("clear_rd", rd_data[31:0], 32'h0);
            @(posedge clk);
            model_edge();
            #1;
         end
         chk("clear_len", 32'(lo), 32'(NREG));
      end
      for (int r = 0; r < NREG; r += 2) begin
         idle_in();
         rd_addr = {5'(r + 1), 5'(r)};
         step();
      end

      // abort a clear with reset at cnt = 10
      for (int r = 1; r < NREG; r++) begin
         idle_in();
         wr_en = 2'b10;
         wr_addr = {5'(r), 5'd0};
         wr_data = {32'hC0DE0000 | 32'(r), 32'h0};
         step();
      end
      idle_in();
      init_req = 1;
      step();
      for (int c = 0; c < 10; c++) begin
         idle_in();
         step();
      end
      rst = 1'b1;
      rd_addr = {5'd31, 5'd12};
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_rd0", rd_data[31:0], 32'h0);
      chk("abort_rd1", rd_data[63:32], 32'h0);
      model_reset();
      #1;
      rst = 1'b0;
      for (int r = 0; r < NREG; r += 2) begin
         idle_in();
         rd_addr = {5'(r + 1), 5'(r)};
         step();
      end

      // random traffic
      for (int c = 0; c < 600; c++) begin
         wr_en = 2'($urandom_range(0, 3));
         wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) == 0)
            wr_addr = 10'($urandom);
         wr_data = {$urandom, $urandom};
         iss_en = 1'($urandom_range(0, 1));
         iss_addr = 5'($urandom_range(0, 7));
         init_req = ($urandom_range(0, 150) == 0);
         rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: register count; AW = clog2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_addr  input  NRD*AW  read addresses; port i occupies slice [i*AW +: AW].
REQ-008 rd_data  output  NRD*XLEN  read data, combinational, port i at [i*XLEN +: XLEN].
REQ-009 rd_busy  output  NRD  scoreboard busy flag of each read register, combinational.
REQ-010 wr_en  input  NWR  per-port write strobe.
REQ-011 wr_addr  input  NWR*AW  write addresses.
REQ-012 wr_data  input  NWR*XLEN  write data.
REQ-013 iss_en  input  1  issue strobe: marks iss_addr pending (busy).
REQ-014 iss_addr  input  AW  destination register of the issued instruction.
REQ-015 init_req  input  1  request a sequential clear of the whole file.
REQ-016 ready  output  1  high when the file is in IDLE and accepting writes and issues.

Function
REQ-017 The file SHALL hold NREG registers of XLEN bits plus one busy bit per register.
REQ-018 Register 0 SHALL always read 0 and SHALL never be written.
REQ-019 Register 0 SHALL never be marked busy.
REQ-020 In IDLE, each write port with wr_en=1 and a non-zero address SHALL update that register at the clock edge.
REQ-021 Two or more write ports targeting the same address in one cycle SHALL resolve so the highest-index port wins.
REQ-022 Reads SHALL bypass: if any enabled write targets rd_addr in the same cycle, rd_data SHALL equal the winning port's wr_data.
REQ-023 Otherwise rd_data SHALL be the stored value.
REQ-024 Busy update: iss_en=1 in IDLE SHALL set busy[iss_addr] at the edge.
REQ-025 Busy update: an enabled write SHALL clear busy[wr_addr] at the edge.
REQ-026 If issue and write target the same register in the same cycle, busy SHALL end set (issue wins) and the data SHALL still be written.
REQ-027 rd_busy[i] SHALL equal busy[rd_addr_i] AND NOT (a same-cycle enabled write to rd_addr_i).
REQ-028 rd_busy[i] SHALL NOT be affected by a same-cycle issue.
REQ-029 FSM states: IDLE and CLEAR.
REQ-030 IDLE -> CLEAR when init_req=1; clear counter loads 0.
REQ-031 In CLEAR, register[cnt] and busy[cnt] SHALL be zeroed each cycle and cnt SHALL increment.
REQ-032 CLEAR -> IDLE in the cycle that cnt = NREG-1 is cleared; the clear therefore lasts exactly NREG cycles.
REQ-033 In CLEAR, ready SHALL be 0; wr_en, iss_en and init_req SHALL be ignored; rd_data and rd_busy SHALL be forced to 0 with no bypass.
REQ-034 ready SHALL be 1 in IDLE, including the cycle init_req is sampled; ready SHALL fall the cycle after init_req is sampled.
REQ-035 Out-of-range addresses (>= NREG, when NREG is not a power of two) SHALL read 0 and busy 0, and writes or issues to them SHALL be ignored.

Reset
REQ-036 rst=1 SHALL immediately force all registers to 0, all busy bits to 0, the FSM to IDLE and cnt to 0, so ready=1, rd_data=0 and rd_busy=0.
REQ-037 rst asserted during CLEAR SHALL abort the clear and return to IDLE with every register zeroed.

Verification
REQ-038 Port 0 writes x5=0xDEADBEEF; next cycle read port 1 at x5 -> 0xDEADBEEF; a write to x0=0x1234 -> reads 0.
REQ-039 Port 0 writes x7=0x11 and port 1 writes x7=0x22 in the same cycle with rd_addr0=7 -> rd_data0=0x22 that cycle; stored value 0x22.
REQ-040 Issue x3; next cycle rd_busy=1; write x3=0x55 with rd_addr=3 -> that cycle rd_busy=0 and rd_data=0x55; following cycle busy=0.
REQ-041 iss_en and wr_en both target x9 in the same cycle -> next cycle busy[9]=1 and x9 holds the written data.
REQ-042 Fill registers, pulse init_req -> ready=0 for exactly NREG cycles; a write during CLEAR has no effect; afterwards all reads are 0 and not busy.
REQ-043 Assert rst mid-CLEAR at cnt=10 -> ready=1 immediately and all registers read 0.
